// File: rtl/vga_frame_arbiter.sv
// vga_frame_arbiter
//   Shares one burst-oriented frame-memory port between the camera writer and
//   the display line-buffer FIFO reader. Whole frames are double-buffered; the
//   address MSB selects frame buffer 0/1. One burst command is in flight at a time.
//
//   Optional build macro: VGA_ARB_RR_EN -- write and normal read alternate
//   round-robin (urgent read keeps top priority). Undefined: fixed priority.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   disp_fstart     display frame-start pulse
//   rd_level        display FIFO fill level (words)
//   wr_fstart       camera frame-start pulse
//   wr_req          writer holds a full burst ready
//   wr_grant        pulse: write burst command accepted
//   rd_grant        pulse: read burst command accepted
//   mem_cmd_valid   command valid to memory controller
//   mem_cmd_ready   controller accepts command
//   mem_cmd_write   1 = write burst, 0 = read burst
//   mem_cmd_addr    burst start word address
//   mem_done        pulse: current burst data phase finished
//   rd_buf          frame buffer currently displayed
module vga_frame_arbiter #(
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned LINE_PIX    = 720,
  parameter int unsigned FRAME_LINES = 576,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned LOW_WM      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_fstart,
  input  logic [9:0]        rd_level,
  input  logic              wr_fstart,
  input  logic              wr_req,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_done,
  output logic              rd_buf
);

  localparam int unsigned FRAME_BURSTS = LINE_PIX * FRAME_LINES / BURST_LEN;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned BL_SH        = $clog2(BURST_LEN);
  localparam int unsigned NORM_WM      = FIFO_DEPTH - 2 * BURST_LEN;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             wr_buf;
  logic             wr_full;
  logic             pend_disp;
  logic             pend_wr;
`ifdef VGA_ARB_RR_EN
  logic             last_wr;
`endif

  logic              apply_disp;
  logic              apply_wr;
  logic              rd_avail;
  logic              urgent_rd;
  logic              norm_rd;
  logic              wr_ok;
  logic              pick_wr;
  logic              pick_rd;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  // Request evaluation for the IDLE arbitration cycle
  always_comb begin
    apply_disp = disp_fstart | pend_disp;
    apply_wr   = wr_fstart | pend_wr;
    rd_avail   = rd_cnt < CNT_W'(FRAME_BURSTS);
    urgent_rd  = rd_avail && (rd_level < 10'(LOW_WM));
    norm_rd    = rd_avail && (rd_level <= 10'(NORM_WM));
    // wr_cnt bound keeps a swapped-but-not-restarted writer from running past the frame
    wr_ok      = wr_req && !wr_full && (wr_cnt < CNT_W'(FRAME_BURSTS));
`ifdef VGA_ARB_RR_EN
    pick_wr    = !urgent_rd && wr_ok && (!norm_rd || !last_wr);
`else
    pick_wr    = !urgent_rd && wr_ok;
`endif
    pick_rd    = urgent_rd || (norm_rd && !pick_wr);
    rd_addr    = {rd_buf, ((ADDR_W-1)'(rd_cnt) << BL_SH)};
    wr_addr    = {wr_buf, ((ADDR_W-1)'(wr_cnt) << BL_SH)};
  end

  // Command FSM, frame bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      wr_buf        <= 1'b1;
      wr_full       <= 1'b0;
      pend_disp     <= 1'b0;
      pend_wr       <= 1'b0;
      rd_buf        <= 1'b0;
      rd_grant      <= 1'b0;
      wr_grant      <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
`ifdef VGA_ARB_RR_EN
      last_wr       <= 1'b0;
`endif
    end else begin
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;

      // Frame starts during a burst are deferred until the FSM is back in IDLE
      if (state != IDLE) begin
        pend_disp <= pend_disp | disp_fstart;
        pend_wr   <= pend_wr | wr_fstart;
      end

      case (state)
        IDLE: begin
          if (apply_disp || apply_wr) begin
            // Frame-start bookkeeping takes this cycle; arbitration resumes next cycle
            pend_disp <= 1'b0;
            pend_wr   <= 1'b0;
            if (apply_disp) begin
              rd_cnt <= '0;
              if (wr_full) begin
                rd_buf <= wr_buf;
                wr_buf <= ~wr_buf;
              end
            end
            if (apply_wr) wr_cnt <= '0;
            if (apply_wr || (apply_disp && wr_full)) wr_full <= 1'b0;
          end else if (pick_wr || pick_rd) begin
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= pick_wr;
            mem_cmd_addr  <= pick_wr ? wr_addr : rd_addr;
            state         <= ISSUE;
`ifdef VGA_ARB_RR_EN
            last_wr       <= pick_wr;
`endif
          end
        end
        ISSUE: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= WAIT;
            if (mem_cmd_write) begin
              wr_grant <= 1'b1;
              wr_cnt   <= wr_cnt + 1'b1;
              if (wr_cnt == CNT_W'(FRAME_BURSTS - 1)) wr_full <= 1'b1;
            end else begin
              rd_grant <= 1'b1;
              rd_cnt   <= rd_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// tb_vga_frame_arbiter
//   Directed bench for vga_frame_arbiter. The frame is scaled down to
//   32 pixels x 2 lines (8 bursts per frame) so full-frame fills stay short.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_vga_frame_arbiter;

  localparam int unsigned FB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_fstart;
  logic [9:0]  rd_level;
  logic        wr_fstart;
  logic        wr_req;
  logic        wr_grant;
  logic        rd_grant;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_write;
  logic [19:0] mem_cmd_addr;
  logic        mem_done;
  logic        rd_buf;

  int n_checks = 0;
  int n_errors = 0;

  // Expected frame state, advanced by hand as bursts are granted
  bit exp_rbuf = 1'b0;
  bit exp_wbuf = 1'b1;
  int exp_rd   = 0;
  int exp_wr   = 0;

  vga_frame_arbiter #(
    .BURST_LEN(8), .LINE_PIX(32), .FRAME_LINES(2),
    .ADDR_W(20), .FIFO_DEPTH(512), .LOW_WM(64)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_fstart(disp_fstart), .rd_level(rd_level),
    .wr_fstart(wr_fstart), .wr_req(wr_req),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_done(mem_done), .rd_buf(rd_buf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for a command, check it, optionally stall ready, accept, finish the burst
  task automatic do_burst(input bit exp_w, input logic [19:0] exp_addr,
                          input int stall, input bit fs_mid);
    int t = 0;
    while (!mem_cmd_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_valid_seen", 32'(mem_cmd_valid), 32'd1);
    if (!mem_cmd_valid) return;
    check("cmd_write", 32'(mem_cmd_write), 32'(exp_w));
    check("cmd_addr", 32'(mem_cmd_addr), 32'(exp_addr));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(mem_cmd_valid), 32'd1);
      check("stall_addr", 32'(mem_cmd_addr), 32'(exp_addr));
      check("stall_write", 32'(mem_cmd_write), 32'(exp_w));
      check("stall_grants", 32'({rd_grant, wr_grant}), 32'd0);
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    mem_cmd_ready = 1'b0;
    check("grant_pulse", 32'({rd_grant, wr_grant}), exp_w ? 32'd1 : 32'd2);
    check("valid_drop", 32'(mem_cmd_valid), 32'd0);
    if (fs_mid) disp_fstart = 1'b1;
    @(negedge clk);
    disp_fstart = 1'b0;
    check("grant_single", 32'({rd_grant, wr_grant}), 32'd0);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
  endtask

  task automatic rd_burst(input int stall, input bit fs_mid);
    do_burst(1'b0, {exp_rbuf, 19'(exp_rd * 8)}, stall, fs_mid);
    exp_rd++;
  endtask

  task automatic wr_burst(input int stall);
    do_burst(1'b1, {exp_wbuf, 19'(exp_wr * 8)}, stall, 1'b0);
    exp_wr++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; disp_fstart = 1'b0; rd_level = 10'd0; wr_fstart = 1'b0;
    wr_req = 1'b0; mem_cmd_ready = 1'b0; mem_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(mem_cmd_valid), 32'd0);
    check("rst_grants", 32'({rd_grant, wr_grant}), 32'd0);
    check("rst_write", 32'(mem_cmd_write), 32'd0);
    check("rst_addr", 32'(mem_cmd_addr), 32'd0);
    check("rst_rd_buf", 32'(rd_buf), 32'd0);

    // Empty FIFO after display frame start: urgent reads from buffer 0
    reset = 1'b0; disp_fstart = 1'b1;
    @(negedge clk);
    disp_fstart = 1'b0;
    rd_burst(0, 1'b0);
    rd_burst(0, 1'b0);

    // Writer after camera frame start fills buffer 1; low FIFO then beats the writer
    rd_level = 10'd100; wr_req = 1'b1; wr_fstart = 1'b1;
    @(negedge clk);
    wr_fstart = 1'b0;
    wr_burst(0);
    rd_level = 10'd10;
    rd_burst(0, 1'b0);

`ifdef VGA_ARB_RR_EN
    rd_level = 10'd100;
    wr_burst(0);
    rd_burst(0, 1'b0);
    wr_burst(0);
    rd_burst(0, 1'b0);
    rd_level = 10'd500;
    while (exp_wr < FB) wr_burst(0);
`else
    // Fixed priority: writes take every slot until the frame is full
    rd_level = 10'd100;
    while (exp_wr < FB) wr_burst(0);
`endif

    // Full frame blocks writes; display frame start during WAIT is deferred
    rd_burst(0, 1'b1);
    exp_rbuf = 1'b1; exp_wbuf = 1'b0; exp_rd = 0;
    rd_burst(0, 1'b0);
    check("swap_rd_buf", 32'(rd_buf), 32'd1);

    // New camera frame goes to the other buffer; second write stalls on ready
    rd_level = 10'd500; wr_fstart = 1'b1;
    @(negedge clk);
    wr_fstart = 1'b0;
    exp_wr = 0;
    wr_burst(0);
    wr_burst(20);

    // Read the rest of the frame, then no more reads until the next frame start
    wr_req = 1'b0; rd_level = 10'd100;
    while (exp_rd < FB) rd_burst(0, 1'b0);
    rd_level = 10'd0;
    begin
      bit seen = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (mem_cmd_valid) seen = 1'b1;
      end
      check("reads_exhausted", 32'(seen), 32'd0);
    end

    // Reset while a command is pending drops valid on the next cycle
    wr_req = 1'b1;
    begin
      int t = 0;
      while (!mem_cmd_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    check("pre_reset_valid", 32'(mem_cmd_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_valid", 32'(mem_cmd_valid), 32'd0);
    check("mid_reset_rd_buf", 32'(rd_buf), 32'd0);
    reset = 1'b0; wr_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
